// File: rtl/i2s_pkg.sv
// i2s_pkg -- shared state type and default geometry for the I2S receive path.
// Revision: 1.0
`default_nettype none

package i2s_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LEFT     = 2'd1,
    RIGHT    = 2'd2
  } i2s_rx_state_t;

  localparam int I2S_DW     = 24;
  localparam int I2S_SLOT_W = 32;

endpackage

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge -- N-flop synchronizer with optional rising-edge pulse.
// Revision: 1.0
`default_nettype none

module i2s_sync_edge #(
  parameter int WIDTH   = 1,
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  if (STAGES < 2) begin : g_bad_stages
    $error("i2s_sync_edge: STAGES must be at least 2");
  end

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic [WIDTH-1:0] dly;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) dly <= '0;
      else      dly <= q;
    end

    assign rise = q & ~dly;
  end else begin : g_no_edge
    assign rise = '0;
  end

endmodule

`default_nettype wire

// File: rtl/i2s_rx_slave.sv
// i2s_rx_slave -- clock-slave I2S receiver: oversampled sclk/lrclk/sdi to stereo words.
// Revision: 1.0
`default_nettype none

module i2s_rx_slave
  import i2s_pkg::*;
#(
  parameter int DW          = I2S_DW,
  parameter int SLOT_W      = I2S_SLOT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk_in,
  input  logic          lrclk_in,
  input  logic          sdi_in,
  output logic [DW-1:0] ldata,
  output logic [DW-1:0] rdata,
  output logic          valid,
  output logic          locked,
  output logic          frame_err
);

  if (SLOT_W <= DW) begin : g_bad_slot_w
    $error("i2s_rx_slave: SLOT_W must exceed DW");
  end

  localparam int            CW       = $clog2(SLOT_W);
  localparam logic [CW-1:0] CNT_DW   = CW'(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_W - 1);

  logic          bit_ev;
  logic          unused_sclk_q;
  logic [1:0]    data_sync;
  logic [1:0]    unused_data_rise;
  logic          lr_s;
  logic          sdi_s;
  logic          lr_prev;
  logic          chg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] shreg;
  logic [DW-1:0] shreg_nxt;
  logic [DW-1:0] stage;
  logic          stage_ld;
  logic          out_ld;
  logic          err_nxt;
  i2s_rx_state_t state;
  i2s_rx_state_t state_nxt;

  i2s_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk_in),
    .q    (unused_sclk_q),
    .rise (bit_ev)
  );

  // lrclk and sdi share the sclk latency so they line up with bit_ev.
  i2s_sync_edge #(.WIDTH(2), .STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({sdi_in, lrclk_in}),
    .q    (data_sync),
    .rise (unused_data_rise)
  );

  assign lr_s  = data_sync[0];
  assign sdi_s = data_sync[1];

  always_comb begin
    chg       = bit_ev && (lr_s != lr_prev);
    cnt_nxt   = chg ? '0 : cnt + CW'(1);
    shreg_nxt = shreg;
    if (cnt_nxt != '0 && cnt_nxt <= CNT_DW) shreg_nxt = {shreg[DW-2:0], sdi_s};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= UNLOCKED;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stage_ld  = 1'b0;
    out_ld    = 1'b0;
    err_nxt   = 1'b0;
    if (bit_ev) begin
      case (state)
        UNLOCKED: if (chg && !lr_s) state_nxt = LEFT;
        LEFT, RIGHT: begin
          // The last cnt of the closing slot decides short vs. normal.
          if (chg) begin
            if (cnt < CNT_DW) begin
              err_nxt   = 1'b1;
              state_nxt = UNLOCKED;
            end else begin
              state_nxt = (state == LEFT) ? RIGHT : LEFT;
            end
          end else if (cnt == CNT_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = UNLOCKED;
          end else if (cnt_nxt == CNT_DW) begin
            if (state == LEFT) stage_ld = 1'b1;
            else               out_ld   = 1'b1;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      shreg     <= '0;
      lr_prev   <= 1'b0;
      stage     <= '0;
      ldata     <= '0;
      rdata     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= out_ld;
      frame_err <= err_nxt;
      if (bit_ev) begin
        cnt     <= cnt_nxt;
        shreg   <= shreg_nxt;
        lr_prev <= lr_s;
      end
      if (stage_ld) stage <= shreg_nxt;
      if (out_ld) begin
        ldata <= stage;
        rdata <= shreg_nxt;
      end
    end
  end

  assign locked = (state != UNLOCKED);

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_slave.sv
// tb_i2s_rx_slave -- table-driven and randomized checks against a slot-level model.
// Revision: 1.0
`default_nettype none

module tb_i2s_rx_slave;

  localparam int DW          = 24;
  localparam int SLOT_W      = 32;
  localparam int SYNC_STAGES = 2;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          sclk_in  = 1'b0;
  logic          lrclk_in = 1'b0;
  logic          sdi_in   = 1'b0;
  logic [DW-1:0] ldata;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          locked;
  logic          frame_err;

  always #5 clk = ~clk;

  i2s_rx_slave #(.DW(DW), .SLOT_W(SLOT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .lrclk_in  (lrclk_in),
    .sdi_in    (sdi_in),
    .ldata     (ldata),
    .rdata     (rdata),
    .valid     (valid),
    .locked    (locked),
    .frame_err (frame_err)
  );

  typedef struct {
    logic          lr;
    int            len;
    logic [DW-1:0] word;
    logic          fill;
  } slot_t;

  typedef struct {
    string         name;
    int            lead;
    int            n;
    int            lens[6];
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          fill;
    int            exp_valids;
    int            exp_errs;
    int            exp_err_pos;
    logic          exp_locked;
  } vec_t;

  slot_t         slots[$];
  logic [2*DW-1:0] exp_pairs[$];
  logic [2*DW-1:0] obs_pairs[$];
  int            exp_errs[$];
  int            obs_errs[$];
  int            bits_sent = 0;
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            age       = 1000;
  logic          sclk_seen = 1'b0;
  logic [DW-1:0] prev_l    = '0;
  logic [DW-1:0] prev_r    = '0;
  logic          prev_rst  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pulse latency/exclusivity, data hold, and event capture.
  always @(posedge clk) begin
    if (sclk_in && !sclk_seen) age = 0;
    else if (age < 1000)       age++;
    sclk_seen = sclk_in;
    #1;
    if (valid || frame_err) begin
      check("pulse_exclusive", 64'(valid & frame_err), 64'd0);
      check("pulse_latency", 64'(age), 64'(SYNC_STAGES));
    end
    if (valid)     obs_pairs.push_back({ldata, rdata});
    if (frame_err) obs_errs.push_back(bits_sent);
    if (rst && prev_rst && !valid)
      check("data_hold", 64'({ldata, rdata}), 64'({prev_l, prev_r}));
    prev_l   = ldata;
    prev_r   = rdata;
    prev_rst = rst;
  end

  task automatic add_slot(input logic lr, input int len, input logic [DW-1:0] word, input logic fill);
    slot_t s;
    s.lr = lr; s.len = len; s.word = word; s.fill = fill;
    slots.push_back(s);
  endtask

  // Slot-level reference: a slot begins at an lrclk transition; its first bit is the
  // delay bit, the next DW bits are the word, a slot of len <= DW closes short and a
  // slot longer than SLOT_W errors on its (SLOT_W+1)th bit.
  task automatic model_run(output logic fin_locked);
    bit            lk    = 0;
    bit            right = 0;
    logic          p_lr  = 1'b0;
    int            p_len = 0;
    int            base  = 0;
    logic [DW-1:0] stg   = '0;
    exp_pairs.delete();
    exp_errs.delete();
    foreach (slots[i]) begin
      if (slots[i].lr != p_lr) begin
        if (lk) begin
          if (p_len <= DW) begin
            exp_errs.push_back(base + 1);
            lk = 0;
          end else begin
            right = slots[i].lr;
          end
        end else if (slots[i].lr == 1'b0) begin
          lk    = 1;
          right = 0;
        end
      end
      if (lk && slots[i].len > DW) begin
        if (right) exp_pairs.push_back({stg, slots[i].word});
        else       stg = slots[i].word;
      end
      if (lk && slots[i].len > SLOT_W) begin
        exp_errs.push_back(base + SLOT_W + 1);
        lk = 0;
      end
      p_lr  = slots[i].lr;
      p_len = slots[i].len;
      base += slots[i].len;
    end
    fin_locked = lk;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    @(negedge clk);
    sclk_in  = 1'b0;
    lrclk_in = lr;
    sdi_in   = d;
    @(negedge clk);
    @(negedge clk);
    sclk_in = 1'b1;
    bits_sent++;
    @(negedge clk);
  endtask

  task automatic drive_slots();
    foreach (slots[i]) begin
      for (int k = 0; k < slots[i].len; k++) begin
        logic b;
        if (k == 0)       b = 1'($urandom_range(0, 1));
        else if (k <= DW) b = slots[i].word[DW-k];
        else              b = slots[i].fill;
        send_bit(slots[i].lr, b);
      end
    end
    @(negedge clk);
    sclk_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset(input logic lr0);
    @(negedge clk);
    rst      = 1'b0;
    sclk_in  = 1'b0;
    lrclk_in = lr0;
    sdi_in   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs_pairs.delete();
    obs_errs.delete();
    bits_sent = 0;
  endtask

  task automatic run_segment(input string name);
    logic mlocked;
    int   n;
    model_run(mlocked);
    do_reset(slots[0].lr);
    drive_slots();
    check($sformatf("%s_model_valids", name), 64'(obs_pairs.size()), 64'(exp_pairs.size()));
    n = (obs_pairs.size() < exp_pairs.size()) ? obs_pairs.size() : exp_pairs.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_model_pair%0d", name, i), 64'(obs_pairs[i]), 64'(exp_pairs[i]));
    check($sformatf("%s_model_errs", name), 64'(obs_errs.size()), 64'(exp_errs.size()));
    n = (obs_errs.size() < exp_errs.size()) ? obs_errs.size() : exp_errs.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_model_errpos%0d", name, i), 64'(obs_errs[i]), 64'(exp_errs[i]));
    check($sformatf("%s_model_locked", name), 64'(locked), 64'(mlocked));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"nominal",   6, 4, '{32, 32, 32, 32,  0,  0}, 24'h123456, 24'hABCDEF, 1'b0, 2, 0,  0, 1'b1};
    vecs[1] = '{"midframe", 20, 2, '{32, 32,  0,  0,  0,  0}, 24'h123456, 24'hABCDEF, 1'b0, 1, 0,  0, 1'b1};
    vecs[2] = '{"short",     3, 6, '{32, 32, 11, 32, 32, 32}, 24'h5A5A5A, 24'hC3C3C3, 1'b0, 2, 1, 79, 1'b1};
    vecs[3] = '{"long_l",    3, 4, '{40, 32, 32, 32,  0,  0}, 24'h0000FF, 24'hFF0000, 1'b1, 1, 1, 36, 1'b1};
    vecs[4] = '{"long_r",    3, 2, '{32, 40,  0,  0,  0,  0}, 24'h111111, 24'h222222, 1'b0, 1, 1, 68, 1'b0};
    vecs[5] = '{"boundary",  2, 4, '{32, 32, 32, 32,  0,  0}, 24'h800000, 24'h7FFFFF, 1'b1, 2, 0,  0, 1'b1};
    vecs[6] = '{"short_fall",3, 5, '{32, 20, 32, 32, 32,  0}, 24'h654321, 24'h0FEDCB, 1'b0, 0, 1, 56, 1'b1};

    #2 rst = 1'b0;
    #1;
    check("reset_ldata",     64'(ldata),     64'd0);
    check("reset_rdata",     64'(rdata),     64'd0);
    check("reset_valid",     64'(valid),     64'd0);
    check("reset_locked",    64'(locked),    64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);

    foreach (vecs[v]) begin
      slots.delete();
      add_slot(1'b1, vecs[v].lead, DW'($urandom()), 1'($urandom_range(0, 1)));
      for (int j = 0; j < vecs[v].n; j++)
        add_slot(1'(j % 2), vecs[v].lens[j], (j % 2 == 0) ? vecs[v].l : vecs[v].r, vecs[v].fill);
      run_segment(vecs[v].name);
      check({vecs[v].name, "_valids"}, 64'(obs_pairs.size()), 64'(vecs[v].exp_valids));
      check({vecs[v].name, "_errs"},   64'(obs_errs.size()),  64'(vecs[v].exp_errs));
      check({vecs[v].name, "_locked"}, 64'(locked),           64'(vecs[v].exp_locked));
      foreach (obs_pairs[i])
        check({vecs[v].name, "_pair"}, 64'(obs_pairs[i]), 64'({vecs[v].l, vecs[v].r}));
      if (obs_errs.size() > 0)
        check({vecs[v].name, "_errpos"}, 64'(obs_errs[0]), 64'(vecs[v].exp_err_pos));
    end

    // Asynchronous reset in the middle of a right slot.
    slots.delete();
    add_slot(1'b1, 3, 24'h0, 1'b0);
    add_slot(1'b0, 32, 24'h13579B, 1'b0);
    add_slot(1'b1, 32, 24'h2468AC, 1'b0);
    add_slot(1'b0, 32, 24'h13579B, 1'b0);
    add_slot(1'b1, 10, 24'h2468AC, 1'b0);
    run_segment("arst_pre");
    check("arst_pre_ldata",  64'(ldata),  64'h13579B);
    check("arst_pre_locked", 64'(locked), 64'd1);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_ldata",     64'(ldata),     64'd0);
    check("arst_rdata",     64'(rdata),     64'd0);
    check("arst_valid",     64'(valid),     64'd0);
    check("arst_locked",    64'(locked),    64'd0);
    check("arst_frame_err", 64'(frame_err), 64'd0);
    slots.delete();
    add_slot(1'b1, 22, 24'h2468AC, 1'b0);
    add_slot(1'b0, 32, 24'h0F0F0F, 1'b0);
    add_slot(1'b1, 32, 24'hF0F0F0, 1'b0);
    run_segment("arst_post");
    check("arst_post_valids", 64'(obs_pairs.size()), 64'd1);
    foreach (obs_pairs[i]) check("arst_post_pair", 64'(obs_pairs[i]), 64'h0F0F0FF0F0F0);

    // Randomized slot streams, mostly well-formed with short/long slots mixed in.
    for (int it = 0; it < 12; it++) begin
      int nsl;
      slots.delete();
      add_slot(1'b1, $urandom_range(1, 31), DW'($urandom()), 1'($urandom_range(0, 1)));
      nsl = $urandom_range(4, 9);
      for (int j = 0; j < nsl; j++) begin
        int r;
        int len;
        r = $urandom_range(0, 99);
        if (r < 65)      len = SLOT_W;
        else if (r < 75) len = $urandom_range(DW + 1, SLOT_W);
        else if (r < 87) len = $urandom_range(2, DW);
        else             len = $urandom_range(SLOT_W + 1, SLOT_W + 6);
        add_slot(1'(j % 2), len, DW'($urandom()), 1'($urandom_range(0, 1)));
      end
      run_segment($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
